// File: rtl/tm_vote_pkg.sv
// tm_vote_pkg: state encoding and width helpers shared by the vote scheduler
package tm_vote_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    function automatic int vote_w(input int n_clauses);
        return $clog2(n_clauses + 1) + 1;
    endfunction
    function automatic int class_w(input int n_classes);
        return n_classes < 2 ? 1 : $clog2(n_classes);
    endfunction
endpackage

// File: rtl/vote_popdiff.sv
// vote_popdiff: signed popcount(pos) - popcount(neg) for one class beat
module vote_popdiff import tm_vote_pkg::*; #(
    parameter int N_CLAUSES = 2,
    localparam int VOTE_W = vote_w(N_CLAUSES)
) (
    input  logic [N_CLAUSES-1:0]     pos,
    input  logic [N_CLAUSES-1:0]     neg,
    output logic signed [VOTE_W-1:0] vote
);
    always_comb begin
        vote = '0;
        for (int i = 0; i < N_CLAUSES; i++) vote = vote + VOTE_W'(pos[i]) - VOTE_W'(neg[i]);
    end
endmodule

// File: rtl/sum_vote_scheduler.sv
// sum_vote_scheduler: scores one clause beat per class and reports the highest-voting class
module sum_vote_scheduler import tm_vote_pkg::*; #(
    parameter int N_CLASSES = 2,
    parameter int N_CLAUSES = 2,
    localparam int VOTE_W = vote_w(N_CLAUSES),
    localparam int CLASS_W = class_w(N_CLASSES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CLAUSES-1:0]     in_pos,
    input  logic [N_CLAUSES-1:0]     in_neg,
    output logic [CLASS_W-1:0]       cur_class,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic signed [VOTE_W-1:0] out_vote
);
    state_t state, state_nx;
    logic signed [VOTE_W-1:0] vote, best_vote;
    logic [CLASS_W-1:0] best_class;
    logic accept, last;

    vote_popdiff #(.N_CLAUSES(N_CLAUSES)) u_popdiff (.pos(in_pos), .neg(in_neg), .vote(vote));

    always_comb begin
        busy      = state != IDLE;
        in_ready  = state == ACCUM;
        out_valid = state == DONE;
        out_class = best_class;
        out_vote  = best_vote;
        accept    = in_valid && in_ready;
        last      = cur_class == CLASS_W'(N_CLASSES - 1);
        state_nx  = state;
        if (state == IDLE && start) state_nx = ACCUM;
        if (accept && last) state_nx = DONE;
        if (out_valid && out_ready) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // class 0 seeds the running best; later classes must strictly beat it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_class  <= '0;
            best_class <= '0;
            best_vote  <= '0;
        end else begin
            if (state == IDLE && start) cur_class <= '0;
            if (accept) begin
                cur_class <= last ? '0 : cur_class + 1'b1;
                if (cur_class == '0 || vote > best_vote) begin
                    best_vote  <= vote;
                    best_class <= cur_class;
                end
            end
        end
    end
endmodule

// File: tb/tb_sum_vote_scheduler.sv
// tb_sum_vote_scheduler: table-driven scoreboard bench for two scheduler configurations
module tb_sum_vote_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic start_a, busy_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [1:0] in_pos_a, in_neg_a;
    logic [0:0] cur_class_a, out_class_a;
    logic signed [2:0] out_vote_a;

    logic start_b, busy_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [2:0] in_pos_b, in_neg_b;
    logic [1:0] cur_class_b, out_class_b;
    logic signed [2:0] out_vote_b;

    sum_vote_scheduler u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_pos(in_pos_a), .in_neg(in_neg_a),
        .cur_class(cur_class_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_class(out_class_a), .out_vote(out_vote_a)
    );

    sum_vote_scheduler #(.N_CLASSES(4), .N_CLAUSES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_pos(in_pos_b), .in_neg(in_neg_b),
        .cur_class(cur_class_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_class(out_class_b), .out_vote(out_vote_b)
    );

    typedef struct {int cls; int vote;} exp_t;
    typedef struct {
        logic [1:0] p0, n0, p1, n1;
        int gap, hold, ec, ev;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // wait for the result, optionally stall the consumer while pulsing start, then handshake
    task automatic drain_a(input int hold);
        exp_t e;
        int t = 0;
        while (!out_valid_a && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("a_out_valid", out_valid_a, 1);
        if (sb.size() == 0) begin
            chk("a_sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("a_out_class", out_class_a, e.cls);
        chk("a_out_vote", out_vote_a, e.vote);
        for (int k = 0; k < hold; k++) begin
            start_a = (k % 2 == 0);
            @(negedge clk);
            chk("a_hold_valid", out_valid_a, 1);
            chk("a_hold_ready", in_ready_a, 0);
            chk("a_hold_class", out_class_a, e.cls);
            chk("a_hold_vote", out_vote_a, e.vote);
        end
        start_a = (hold > 0);
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        start_a = 1'b0;
        chk("a_done_valid", out_valid_a, 0);
        chk("a_done_busy", busy_a, 0);
        chk("a_done_in_ready", in_ready_a, 0);
    endtask

    task automatic run_a(input vec_t v);
        exp_t e;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_busy", busy_a, 1);
        chk("a_in_ready", in_ready_a, 1);
        e.cls = v.ec;
        e.vote = v.ev;
        sb.push_back(e);
        chk("a_cur0", cur_class_a, 0);
        in_valid_a = 1'b1; in_pos_a = v.p0; in_neg_a = v.n0;
        @(negedge clk);
        in_valid_a = 1'b0;
        for (int g = 0; g < v.gap; g++) begin
            in_pos_a = 2'($urandom);
            in_neg_a = 2'($urandom);
            @(negedge clk);
            chk("a_gap_cur", cur_class_a, 1);
        end
        chk("a_cur1", cur_class_a, 1);
        in_valid_a = 1'b1; in_pos_a = v.p1; in_neg_a = v.n1;
        @(negedge clk);
        in_valid_a = 1'b0;
        drain_a(v.hold);
    endtask

    task automatic run_b(input logic [2:0] p[4], input logic [2:0] n[4], input int ec, input int ev);
        exp_t e;
        int t = 0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        e.cls = ec;
        e.vote = ev;
        sb.push_back(e);
        for (int c = 0; c < 4; c++) begin
            chk("b_cur", cur_class_b, c);
            in_valid_b = 1'b1; in_pos_b = p[c]; in_neg_b = n[c];
            @(negedge clk);
            in_valid_b = 1'b0;
        end
        while (!out_valid_b && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("b_out_valid", out_valid_b, 1);
        if (sb.size() == 0) begin
            chk("b_sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("b_out_class", out_class_b, e.cls);
        chk("b_out_vote", out_vote_b, e.vote);
        out_ready_b = 1'b1;
        @(negedge clk);
        out_ready_b = 1'b0;
        chk("b_done_valid", out_valid_b, 0);
    endtask

    initial begin
        logic [2:0] bp[4];
        logic [2:0] bn[4];
        tbl[0] = '{p0:2'b11, n0:2'b00, p1:2'b01, n1:2'b00, gap:0, hold:0, ec:0, ev:2};
        tbl[1] = '{p0:2'b01, n0:2'b01, p1:2'b01, n1:2'b01, gap:0, hold:0, ec:0, ev:0};
        tbl[2] = '{p0:2'b00, n0:2'b11, p1:2'b00, n1:2'b00, gap:2, hold:0, ec:1, ev:0};
        tbl[3] = '{p0:2'b00, n0:2'b01, p1:2'b10, n1:2'b00, gap:0, hold:0, ec:1, ev:1};
        tbl[4] = '{p0:2'b11, n0:2'b11, p1:2'b00, n1:2'b10, gap:1, hold:0, ec:0, ev:0};
        tbl[5] = '{p0:2'b00, n0:2'b11, p1:2'b01, n1:2'b11, gap:0, hold:0, ec:1, ev:-1};
        tbl[6] = '{p0:2'b10, n0:2'b00, p1:2'b11, n1:2'b00, gap:0, hold:3, ec:1, ev:2};

        rst_n = 1'b0;
        {start_a, in_valid_a, out_ready_a, in_pos_a, in_neg_a} = '0;
        {start_b, in_valid_b, out_ready_b, in_pos_b, in_neg_b} = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_cur_class", cur_class_a, 0);
        chk("rst_out_class", out_class_a, 0);
        chk("rst_out_vote", out_vote_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_a(tbl[i]);

        // reset after the class-0 beat discards the partial result
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        in_valid_a = 1'b1; in_pos_a = 2'b11; in_neg_a = 2'b00;
        @(negedge clk);
        in_valid_a = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_valid", out_valid_a, 0);
        chk("mid_rst_cur", cur_class_a, 0);
        chk("mid_rst_vote", out_vote_a, 0);
        @(negedge clk);
        chk("post_rst_valid", out_valid_a, 0);
        run_a('{p0:2'b00, n0:2'b01, p1:2'b00, n1:2'b11, gap:0, hold:0, ec:0, ev:-1});

        bp = '{3'b000, 3'b111, 3'b111, 3'b000};
        bn = '{3'b001, 3'b000, 3'b000, 3'b111};
        run_b(bp, bn, 1, 3);
        bp = '{3'b000, 3'b000, 3'b001, 3'b000};
        bn = '{3'b111, 3'b111, 3'b111, 3'b111};
        run_b(bp, bn, 2, -2);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
